mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one memory port between the instruction fetch unit (instruction queue memreq/memresp) and the data-access stage.
- Arbitrates requests and tracks in-flight ownership in a small owner FIFO, so that in-order memory responses return to the correct requester.
- Discards fetch responses that a branch-mispredict flush has made stale.
- Sits between the fetch/LSU stages and the single-ported memory.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data/instruction width.
- OUTSTANDING, 4, maximum accepted-but-unanswered memory requests (owner FIFO depth, power of two, ≥2).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- i_req_valid  in  1  fetch request.
- i_req_ready  out  1  fetch request accepted.
- i_req_addr  in  ADDR_W  fetch address.
- i_resp_valid  out  1  fetch response.
- i_resp_addr  out  ADDR_W  address of the returned fetch.
- i_resp_data  out  DATA_W  returned instruction.
- i_flush  in  1  mispredict; invalidates all in-flight fetches.
- d_req_valid  in  1  data request.
- d_req_ready  out  1  data request accepted.
- d_req_addr  in  ADDR_W  data address.
- d_req_wen  in  1  1 = write.
- d_req_wdata  in  DATA_W  write data.
- d_resp_valid  out  1  data response (reads and writes).
- d_resp_data  out  DATA_W  read data.
- m_req_valid  out  1  memory request.
- m_req_ready  in  1  memory accepts.
- m_req_addr  out  ADDR_W  request address.
- m_req_wen  out  1  write enable.
- m_req_wdata  out  DATA_W  write data.
- m_resp_valid  in  1  memory response, one per accepted request, in order.
- m_resp_data  in  DATA_W  response data.

Behaviour:

Reset (rst_n low, asynchronous):
- Owner FIFO empty: head/tail/count = 0.
- Grant lock cleared.
- Round-robin pointer = fetch.
- All *_ready and *_valid outputs = 0.

Handshake and capacity:
- A transfer occurs on valid & ready.
- Requesters hold valid/addr/wdata stable until ready.
- full = (count == OUTSTANDING). While full, m_req_valid = 0 even if a pop happens in the same cycle.

Grant states:
- UNLOCKED:
  - The winner is chosen combinationally from the valid requesters.
  - Fetch is not eligible in a cycle where i_flush = 1.
  - m_req_* mux the winner's fields; fetch drives m_req_wen = 0 and m_req_wdata = 0.
- LOCKED_I / LOCKED_D:
  - Entered when m_req_valid = 1 and m_req_ready = 0. The grant is held on that requester until its handshake.
  - i_flush while in LOCKED_I returns the arbiter to UNLOCKED.
  - Any handshake returns the arbiter to UNLOCKED.
- Ready routing: winner_ready = m_req_ready & m_req_valid. The loser's ready = 0.

Owner FIFO:
- Push on each m_req handshake: {owner, discard = 0, addr}.
- Pop on each m_resp_valid. Pointers wrap modulo OUTSTANDING.
- Push and pop in the same cycle leave count unchanged.

Response routing (combinational, 0-cycle):
- i_resp_valid = m_resp_valid & head.owner == I & !head.discard & !i_flush.
- i_resp_addr = head.addr; i_resp_data = m_resp_data.
- d_resp_valid = m_resp_valid & head.owner == D; d_resp_data = m_resp_data.
- A discarded head is popped silently.

Flush:
- i_flush sets discard on every FIFO entry with owner I, including an entry pushed in the same cycle.
- Data entries are untouched.

Error case:
- m_resp_valid while the FIFO is empty is ignored; a simulation-only assertion fires.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - When both requesters are valid in UNLOCKED, grant goes to the requester not granted last.
  - The pointer updates on each handshake.
  - Under continuous contention, grants strictly alternate I, D, I, D.
- Undefined:
  - Fixed priority, data over fetch.
  - The pointer logic is not built.

Test Plan:
1. Reset mid-traffic: 2 fetches in flight, assert rst_n = 0 -> all valids/readies 0 immediately. After release, count = 0 and a stray m_resp_valid produces no i_resp_valid or d_resp_valid.
2. Fetch 0x100, then data read 0x2000; memory answers 0xAAAA then 0xBBBB -> i_resp_valid with addr 0x100 / data 0xAAAA, then d_resp_valid with data 0xBBBB.
3. Three fetches 0x0/0x4/0x8 in flight, i_flush pulses, new fetch 0x40 issued -> the first three responses produce no i_resp_valid; the fourth response gives i_resp_addr 0x40.
4. m_req_ready held 0 for 3 cycles while fetch is pending, data raises valid at cycle 1 -> m_req_addr stays the fetch address (LOCKED_I) until the handshake; data is granted on the next handshake.
5. OUTSTANDING = 4, memory never responds -> exactly 4 handshakes, then m_req_valid = 0. One response -> the next request issues the following cycle.
6. Both requesters valid continuously -> without ARB_ROUND_ROBIN_EN all grants go to D; with it, grants alternate I/D starting with I after reset.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one in-order memory port between instruction fetch and data access.
// Each accepted request records its owner in a small FIFO, so every in-order
// memory response can be routed back to the requester that issued it. A
// branch-mispredict flush marks in-flight fetches stale; their responses are
// then dropped without being forwarded.
//
// Build option: define ARB_ROUND_ROBIN_EN for round-robin arbitration between
// the two requesters. Without it, data requests have fixed priority over fetch.
module mem_port_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int OUTSTANDING = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   // instruction fetch side
   input  logic              i_req_valid,
   output logic              i_req_ready,
   input  logic [ADDR_W-1:0] i_req_addr,
   output logic              i_resp_valid,
   output logic [ADDR_W-1:0] i_resp_addr,
   output logic [DATA_W-1:0] i_resp_data,
   input  logic              i_flush,
   // data access side
   input  logic              d_req_valid,
   output logic              d_req_ready,
   input  logic [ADDR_W-1:0] d_req_addr,
   input  logic              d_req_wen,
   input  logic [DATA_W-1:0] d_req_wdata,
   output logic              d_resp_valid,
   output logic [DATA_W-1:0] d_resp_data,
   // memory side
   output logic              m_req_valid,
   input  logic              m_req_ready,
   output logic [ADDR_W-1:0] m_req_addr,
   output logic              m_req_wen,
   output logic [DATA_W-1:0] m_req_wdata,
   input  logic              m_resp_valid,
   input  logic [DATA_W-1:0] m_resp_data
);

   localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
   localparam int CNT_W = PTR_W + 1;

   // owner encoding stored per FIFO entry
   localparam logic OWN_I = 1'b0;
   localparam logic OWN_D = 1'b1;

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      LOCKED_I = 2'd1,
      LOCKED_D = 2'd2
   } lock_t;

   lock_t             lock_state;
   lock_t             lock_eff;

   logic [PTR_W-1:0]  head;
   logic [PTR_W-1:0]  tail;
   logic [CNT_W-1:0]  count;

   logic              fifo_owner   [OUTSTANDING];
   logic              fifo_discard [OUTSTANDING];
   logic [ADDR_W-1:0] fifo_addr    [OUTSTANDING];

   logic              full;
   logic              empty;
   logic              i_elig;
   logic              d_elig;
   logic              pick_d;
   logic              sel_i;
   logic              sel_d;
   logic              req_any;
   logic              push;
   logic              pop;

   assign full   = (count == CNT_W'(OUTSTANDING));
   assign empty  = (count == '0);

   // a flushing fetch unit has nothing valid to ask for this cycle
   assign i_elig = i_req_valid & ~i_flush;
   assign d_elig = d_req_valid;

`ifdef ARB_ROUND_ROBIN_EN
   // set when data should win the next contended arbitration
   logic rr_prefer_d;

   assign pick_d = d_elig & (~i_elig | rr_prefer_d);

   // Round-robin pointer: after each handshake prefer the other requester
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_prefer_d <= 1'b0;
      end else if (push) begin
         rr_prefer_d <= sel_i;
      end
   end
`else
   assign pick_d = d_elig;
`endif

   // Effective lock: a flush aborts a stalled fetch grant in the same cycle
   always_comb begin
      lock_eff = lock_state;
      if ((lock_state == LOCKED_I) && i_flush) begin
         lock_eff = UNLOCKED;
      end
   end

   // Grant selection: honour a held lock, otherwise arbitrate the eligible requesters
   always_comb begin
      sel_i = 1'b0;
      sel_d = 1'b0;
      case (lock_eff)
         LOCKED_I: sel_i = 1'b1;
         LOCKED_D: sel_d = 1'b1;
         default: begin
            sel_d = pick_d;
            sel_i = ~pick_d & i_elig;
         end
      endcase
   end

   // No request may issue while every owner slot is in use, even if a
   // response frees one this same cycle; that keeps push independent of pop.
   assign req_any     = (sel_i & i_req_valid) | (sel_d & d_req_valid);
   assign m_req_valid = rst_n & ~full & req_any;
   assign push        = m_req_valid & m_req_ready;

   assign i_req_ready = push & sel_i;
   assign d_req_ready = push & sel_d;

   assign m_req_addr  = sel_d ? d_req_addr : i_req_addr;
   assign m_req_wen   = sel_d & d_req_wen;
   assign m_req_wdata = sel_d ? d_req_wdata : '0;

   // Responses are consumed only when something is outstanding; a stray
   // response on an empty FIFO is ignored.
   assign pop          = rst_n & m_resp_valid & ~empty;

   assign i_resp_valid = pop & (fifo_owner[head] == OWN_I) & ~fifo_discard[head] & ~i_flush;
   assign i_resp_addr  = fifo_addr[head];
   assign i_resp_data  = m_resp_data;

   assign d_resp_valid = pop & (fifo_owner[head] == OWN_D);
   assign d_resp_data  = m_resp_data;

   // Grant lock FSM: a stalled request keeps the port until it handshakes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_state <= UNLOCKED;
      end else if (push) begin
         lock_state <= UNLOCKED;
      end else if (m_req_valid) begin
         lock_state <= sel_d ? LOCKED_D : LOCKED_I;
      end else begin
         lock_state <= UNLOCKED;
      end
   end

   // Owner FIFO pointers and occupancy; pointers wrap at the power-of-two depth
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            tail <= tail + PTR_W'(1);
         end
         if (pop) begin
            head <= head + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Owner FIFO storage: stale-mark fetch entries on flush, then record a new entry
   always_ff @(posedge clk) begin
      for (int k = 0; k < OUTSTANDING; k++) begin
         if (i_flush && (fifo_owner[k] == OWN_I)) begin
            fifo_discard[k] <= 1'b1;
         end
      end
      if (push) begin
         fifo_owner[tail]   <= sel_d ? OWN_D : OWN_I;
         fifo_discard[tail] <= ~sel_d & i_flush;
         fifo_addr[tail]    <= m_req_addr;
      end
   end

`ifndef SYNTHESIS
   // the memory must never answer more requests than were issued
   resp_without_request : assert property (
      @(posedge clk) disable iff (!rst_n) !(m_resp_valid && empty)
   ) else $error("mem_port_arbiter: memory response with no request outstanding");
`endif

endmodule
